hpdcache_mem_req_read_rr_credit_arbiter: RTL

Round-robin arbiter with per-requester credit limiting for the memory read request channel. Shares one downstream read request port among N internal requesters (miss handler, prefetcher, uncached unit). Grants are locked while a request is stalled. Each requester's in-flight reads are capped at MAX_OUTSTANDING, and a credit is returned when the matching response completes. It sits between the requesters and the memory interface, in place of a fixed-priority read arbiter.

---
 rtl/hpdcache_mem_req_read_rr_credit_arbiter_pkg.sv | 18 +
 rtl/hpdcache_mem_req_read_rr_credit_arbiter_if.sv | 32 +++
 rtl/hpdcache_rrarb_lock.sv | 88 ++++++++
 rtl/hpdcache_mem_req_read_rr_credit_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/hpdcache_mem_req_read_rr_credit_arbiter_pkg.sv
// Shared definitions for the credit-limited round-robin read request arbiter.
package hpdcache_mem_req_read_rr_credit_arbiter_pkg;

    typedef enum logic {
        ARB_ST  = 1'b0,
        HOLD_ST = 1'b1
    } arb_state_e;

    // Index width never collapses to zero, even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/hpdcache_mem_req_read_rr_credit_arbiter_if.sv
// Read request channel bundle: N requester-side handshakes plus the single downstream port.
interface hpdcache_mem_req_read_rr_credit_arbiter_if #(
    parameter int unsigned N                  = 2,
    parameter type         hpdcache_mem_req_t = logic
);

    logic [N-1:0]      mem_req_read_valid_i;
    logic [N-1:0]      mem_req_read_ready_o;
    hpdcache_mem_req_t mem_req_read_i [N];
    logic              mem_req_read_ready_i;
    logic              mem_req_read_valid_o;
    hpdcache_mem_req_t mem_req_read_o;

    modport slave (
        input  mem_req_read_valid_i,
        input  mem_req_read_i,
        input  mem_req_read_ready_i,
        output mem_req_read_ready_o,
        output mem_req_read_valid_o,
        output mem_req_read_o
    );

    modport master (
        output mem_req_read_valid_i,
        output mem_req_read_i,
        output mem_req_read_ready_i,
        input  mem_req_read_ready_o,
        input  mem_req_read_valid_o,
        input  mem_req_read_o
    );

endinterface

// File: rtl/hpdcache_rrarb_lock.sv
// Round-robin priority search with a grant lock held while the downstream stalls.
module hpdcache_rrarb_lock
    import hpdcache_mem_req_read_rr_credit_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [N-1:0] gnt_c,
    output logic         valid_c
);

    localparam int unsigned IW = idx_width(N);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            search_hit;
    logic [IW-1:0]   search_idx;
    logic [IW-1:0]   gnt_idx;
    int unsigned     j;

    // First requesting index at or after rr_ptr, wrapping modulo N.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        j          = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(rr_ptr_q) + k) % N;
            if (!search_hit && req[IW'(j)]) begin
                search_hit = 1'b1;
                search_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        valid_c    = 1'b0;
        gnt_idx    = '0;
        gnt_c      = '0;

        case (state_q)
            ARB_ST: begin
                valid_c = search_hit;
                gnt_idx = search_idx;
                if (search_hit && !ready) begin
                    state_d    = HOLD_ST;
                    lock_idx_d = search_idx;
                end
            end
            HOLD_ST: begin
                // Requester must keep its request up, so the grant is simply replayed.
                valid_c = 1'b1;
                gnt_idx = lock_idx_q;
                if (ready) begin
                    state_d = ARB_ST;
                end
            end
            default: state_d = ARB_ST;
        endcase

        for (int unsigned i = 0; i < N; i++) begin
            gnt_c[i] = valid_c && (gnt_idx == IW'(i));
        end

        if (valid_c && ready) begin
            rr_ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_ST;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/hpdcache_mem_req_read_rr_credit_arbiter.sv
// Memory read request arbiter: round-robin with lock on stall, per-requester outstanding-read credits.
module hpdcache_mem_req_read_rr_credit_arbiter
    import hpdcache_mem_req_read_rr_credit_arbiter_pkg::*;
#(
    parameter int unsigned N                  = 2,
    parameter int unsigned MAX_OUTSTANDING    = 4,
    parameter type         hpdcache_mem_req_t = logic
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    hpdcache_mem_req_read_rr_credit_arbiter_if.slave mem_req,
    output logic [idx_width(N)-1:0]                gnt_index_o,
    input  logic                                   rsp_done_i,
    input  logic [idx_width(N)-1:0]                rsp_index_i,
    output logic [N-1:0]                           credit_full_o,
    output logic                                   credit_err_o
);

    localparam int unsigned IW = idx_width(N);
    localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

    logic [CW-1:0]     cnt_q [N];
    logic [CW-1:0]     cnt_d [N];
    logic              err_q, err_d;
    logic [N-1:0]      eligible;
    logic [N-1:0]      gnt_oh;
    logic              arb_valid;
    logic              xfer;
    logic [IW-1:0]     gnt_idx;
    hpdcache_mem_req_t sel_req;
    logic              rsp_bad;
    logic              inc, hit, dec;

    // Eligibility only sees registered credits, so a release never reaches the request path.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = mem_req.mem_req_read_valid_i[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    hpdcache_rrarb_lock #(
        .N (N)
    ) u_rrarb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (eligible),
        .ready   (mem_req.mem_req_read_ready_i),
        .gnt_c   (gnt_oh),
        .valid_c (arb_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx = gnt_idx | IW'(i);
            end
        end
    end

    assign sel_req                      = mem_req.mem_req_read_i[gnt_idx];
    assign xfer                         = arb_valid && mem_req.mem_req_read_ready_i;
    assign mem_req.mem_req_read_valid_o = arb_valid;
    assign mem_req.mem_req_read_o       = sel_req;
    assign mem_req.mem_req_read_ready_o = gnt_oh & {N{mem_req.mem_req_read_ready_i}};
    assign gnt_index_o                  = gnt_idx;
    assign credit_err_o                 = err_q;

    // Credit counters: a release on an empty counter or an unknown index is ignored and flagged.
    always_comb begin
        err_d   = err_q;
        rsp_bad = rsp_done_i && (32'(rsp_index_i) >= N);
        inc     = 1'b0;
        hit     = 1'b0;
        dec     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            inc      = xfer && gnt_oh[i];
            hit      = rsp_done_i && (rsp_index_i == IW'(i));
            dec      = hit && (cnt_q[i] != '0);
            if (hit && (cnt_q[i] == '0)) begin
                rsp_bad = 1'b1;
            end
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        if (rsp_bad) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            credit_full_o[i] = (cnt_q[i] == CW'(MAX_OUTSTANDING));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule
